// File: rtl/acia_pkg.sv
// acia_pkg
//   Shared definitions for the 6551 ACIA transmit sequencer:
//   - register-select encodings for the ACIA register file
//   - status register bit indices
//   - sequencer state enum
//   - packed bus-cycle record and helpers that build idle/read/write cycles
package acia_pkg;

  // Register select (rs[1:0]) encodings
  localparam logic [1:0] RS_DATA    = 2'b00;
  localparam logic [1:0] RS_STATUS  = 2'b01;  // read: status, write: programmed reset
  localparam logic [1:0] RS_COMMAND = 2'b10;
  localparam logic [1:0] RS_CONTROL = 2'b11;

  // Status register bit indices
  localparam int ST_PE    = 0;
  localparam int ST_FE    = 1;
  localparam int ST_OVRN  = 2;
  localparam int ST_RDRF  = 3;
  localparam int ST_TDRE  = 4;
  localparam int ST_DCD_N = 5;
  localparam int ST_DSR_N = 6;
  localparam int ST_IRQ   = 7;

  typedef enum logic [2:0] {
    IDLE,
    RST_W,
    CTRL_W,
    CMD_W,
    READY,
    POLL_ADDR,
    POLL_SAMPLE,
    TX_W
  } seq_state_t;

  // One registered bus cycle as presented to the ACIA
  typedef struct packed {
    logic       cs_n;
    logic       rw;
    logic       en;
    logic [1:0] rs;
    logic [7:0] wdata;
  } acia_bus_t;

  function automatic acia_bus_t bus_idle();
    acia_bus_t b;
    b.cs_n  = 1'b1;
    b.rw    = 1'b1;
    b.en    = 1'b0;
    b.rs    = RS_DATA;
    b.wdata = 8'h00;
    return b;
  endfunction

  function automatic acia_bus_t bus_read(input logic [1:0] rs);
    acia_bus_t b;
    b.cs_n  = 1'b0;
    b.rw    = 1'b1;
    b.en    = 1'b0;
    b.rs    = rs;
    b.wdata = 8'h00;
    return b;
  endfunction

  function automatic acia_bus_t bus_write(input logic [1:0] rs, input logic [7:0] data);
    acia_bus_t b;
    b.cs_n  = 1'b0;
    b.rw    = 1'b0;
    b.en    = 1'b1;
    b.rs    = rs;
    b.wdata = data;
    return b;
  endfunction

endpackage

// File: rtl/acia_seq_fifo.sv
// acia_seq_fifo
//   Small synchronous FIFO holding bytes waiting to be written to the ACIA.
//   Push is ignored when full, pop is ignored when empty; a simultaneous
//   push and pop both take effect and leave the occupancy unchanged.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset (pointers only)
//     push, din     write request and data
//     pop           discard the current head
//     head          oldest entry, valid whenever empty=0
//     full, empty   occupancy flags
module acia_seq_fifo #(
  parameter int DEPTH = 8,   // power of two, >= 2
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head is read asynchronously: the sequencer captures it on the same
  // clk_en edge that pops it, so there is no read latency to hide.
  assign head = mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/acia_tx_sequencer.sv
// acia_tx_sequencer
//   Bus master for a 6551-style ACIA. On start it issues a programmed reset,
//   writes the control and command registers, then drains a local byte FIFO
//   into the TX data register, polling status TDRE before every byte.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     clk_en            bus/FSM clock enable (same strobe the ACIA uses)
//     start             begin configuration (only honoured in IDLE)
//     cfg_control       value written to the control register (rs=11)
//     cfg_command       value written to the command register (rs=10)
//     wr_data/valid     byte producer; accepted when wr_valid & wr_ready
//     wr_ready          FIFO not full
//     acia_cs_n/rw/en   registered bus controls (write: cs_n=0, rw=0, en=1)
//     acia_rs/wdata     registered register select and write data
//     acia_rdata        ACIA read data, valid one clk_en after the read cycle
//     configured        configuration sequence finished
//     busy              FIFO non-empty or a byte is in flight
//     err_timeout       sticky: a byte was dropped after POLL_LIMIT status reads
module acia_tx_sequencer
  import acia_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,     // power of two, >= 2
  parameter int POLL_LIMIT = 1024,  // >= 1
  parameter int TDRE_BIT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       start,
  input  logic [7:0] cfg_control,
  input  logic [7:0] cfg_command,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       acia_cs_n,
  output logic       acia_rw,
  output logic       acia_en,
  output logic [1:0] acia_rs,
  output logic [7:0] acia_wdata,
  input  logic [7:0] acia_rdata,
  output logic       configured,
  output logic       busy,
  output logic       err_timeout
);

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);
  localparam logic [CNT_W-1:0] POLL_MAX = CNT_W'(POLL_LIMIT);

  seq_state_t       state_reg;
  acia_bus_t        bus_reg;
  logic [CNT_W-1:0] poll_cnt_reg;
  logic [CNT_W-1:0] poll_cnt_next;
  logic             configured_reg;
  logic             err_reg;

  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       tdre;
  logic       poll_expired;
  logic       unused_rdata;

  // ---------------------------------------------------------------------------
  // TX byte FIFO: pushes on any clk edge, pops only on clk_en edges.
  // ---------------------------------------------------------------------------
  acia_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .din   (wr_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr_ready = !fifo_full;

  // Only TDRE matters here; the remaining status bits are deliberately ignored.
  assign tdre         = acia_rdata[TDRE_BIT];
  assign unused_rdata = ^acia_rdata;

  // Poll count including the sample being evaluated now.
  assign poll_cnt_next = poll_cnt_reg + 1'b1;
  assign poll_expired  = !tdre && (poll_cnt_next >= POLL_MAX);

  // The head leaves the FIFO either by being written (TDRE seen) or by being
  // discarded after the last permitted poll.
  assign fifo_pop = clk_en && (state_reg == POLL_SAMPLE) && (tdre || poll_expired);

  assign busy = !fifo_empty || (state_reg inside {POLL_ADDR, POLL_SAMPLE, TX_W});

  assign acia_cs_n   = bus_reg.cs_n;
  assign acia_rw     = bus_reg.rw;
  assign acia_en     = bus_reg.en;
  assign acia_rs     = bus_reg.rs;
  assign acia_wdata  = bus_reg.wdata;
  assign configured  = configured_reg;
  assign err_timeout = err_reg;

  // ---------------------------------------------------------------------------
  // Sequencer. The bus record is loaded on the edge that enters a state, so
  // the ACIA sees that state's cycle for exactly one clk_en period.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      bus_reg        <= bus_idle();
      poll_cnt_reg   <= '0;
      configured_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else if (clk_en) begin
      case (state_reg)
        IDLE: begin
          bus_reg <= bus_idle();
          if (start) begin
            state_reg <= RST_W;
            // Programmed reset: any write to the status address.
            bus_reg   <= bus_write(RS_STATUS, 8'h00);
            err_reg   <= 1'b0;
          end
        end
        RST_W: begin
          state_reg <= CTRL_W;
          bus_reg   <= bus_write(RS_CONTROL, cfg_control);
        end
        CTRL_W: begin
          state_reg <= CMD_W;
          bus_reg   <= bus_write(RS_COMMAND, cfg_command);
        end
        CMD_W: begin
          state_reg      <= READY;
          bus_reg        <= bus_idle();
          configured_reg <= 1'b1;
        end
        READY: begin
          bus_reg <= bus_idle();
          if (!fifo_empty) begin
            state_reg    <= POLL_ADDR;
            bus_reg      <= bus_read(RS_STATUS);
            poll_cnt_reg <= '0;
          end
        end
        POLL_ADDR: begin
          // The ACIA registers its read data on this edge; it is examined
          // during POLL_SAMPLE.
          state_reg <= POLL_SAMPLE;
          bus_reg   <= bus_idle();
        end
        POLL_SAMPLE: begin
          poll_cnt_reg <= poll_cnt_next;
          if (tdre) begin
            state_reg <= TX_W;
            bus_reg   <= bus_write(RS_DATA, fifo_head);
          end else if (poll_expired) begin
            state_reg <= READY;
            bus_reg   <= bus_idle();
            err_reg   <= 1'b1;
          end else begin
            state_reg <= POLL_ADDR;
            bus_reg   <= bus_read(RS_STATUS);
          end
        end
        TX_W: begin
          state_reg <= READY;
          bus_reg   <= bus_idle();
        end
        default: begin
          state_reg <= IDLE;
          bus_reg   <= bus_idle();
        end
      endcase
    end
  end

endmodule
